// File: rtl/opb_register_simulink2ppc_pkg.sv
// rtl/opb_register_simulink2ppc_pkg.sv - shared offsets, status bits, FSM states and OPB bit-order helpers
package opb_register_simulink2ppc_pkg;

  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_COUNT  = 32'h0000_0008;

  localparam int STAT_NEW = 0;
  localparam int STAT_OVR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } ack_state_t;

  // OPB numbers bit 0 as the MSB: opb[i] carries reg[31-i].
  function automatic logic [31:0] opb_to_reg(input logic [0:31] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  function automatic logic [0:31] reg_to_opb(input logic [31:0] v);
    logic [0:31] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// rtl/opb_slave_ack_fsm.sv - address decode and IDLE/ACK/GAP acknowledge sequencing
module opb_slave_ack_fsm
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_00FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        select,
  input  logic        rnw,
  output logic        start,
  output logic [31:0] start_off,
  output logic        ack,
  output logic        rd_en,
  output logic        wr_en,
  output logic [31:0] acc_off
);

  ack_state_t  state, state_d;
  logic        in_window;
  logic        rnw_q;
  logic [31:0] off_q;

  assign in_window = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign start_off = addr - C_BASEADDR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      off_q <= '0;
      rnw_q <= 1'b0;
    end else begin
      state <= state_d;
      if (start) begin
        off_q <= start_off;
        rnw_q <= rnw;
      end
    end
  end

  // GAP ignores select so a master still holding it after the ack is not acked twice.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    case (state)
      IDLE: if (select && in_window) begin
        start   = 1'b1;
        state_d = ACK;
      end
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ack     = (state == ACK);
  assign rd_en   = ack && rnw_q;
  assign wr_en   = ack && !rnw_q;
  assign acc_off = off_q;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// rtl/opb_register_simulink2ppc.sv - fabric-to-PowerPC OPB register with new/overrun flags and capture counter
module opb_register_simulink2ppc
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid
);

  logic        start, ack, rd_en, wr_en;
  logic [31:0] start_off, acc_off;
  logic [31:0] data_q, count_q, rd_q, rd_mux, wdata;
  logic        new_q, ovr_q;
  logic        rd_clr, w1c;
  logic        unused_ok;

  opb_slave_ack_fsm #(
    .C_BASEADDR(C_BASEADDR),
    .C_HIGHADDR(C_HIGHADDR)
  ) u_fsm (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .addr     (OPB_ABus),
    .select   (OPB_select),
    .rnw      (OPB_RNW),
    .start    (start),
    .start_off(start_off),
    .ack      (ack),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .acc_off  (acc_off)
  );

  assign wdata     = opb_to_reg(OPB_DBus);
  assign rd_clr    = rd_en && (acc_off == OFF_DATA);
  assign w1c       = wr_en && (acc_off == OFF_STATUS) && OPB_BE[3];
  assign unused_ok = &{1'b0, OPB_seqAddr, OPB_BE[0:2], wdata[31:2]};

  always_comb begin
    rd_mux = '0;
    case (start_off)
      OFF_DATA:   rd_mux = data_q;
      OFF_STATUS: rd_mux = {30'd0, ovr_q, new_q};
      OFF_COUNT:  rd_mux = count_q;
      default:    rd_mux = '0;
    endcase
  end

  // A capture always wins over a same-cycle read-clear or W1C.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      rd_q    <= '0;
      new_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (start) rd_q <= rd_mux;
      if (user_valid) begin
        data_q  <= user_data_in;
        count_q <= count_q + 32'd1;
      end
      if (user_valid) new_q <= 1'b1;
      else if (rd_clr || (w1c && wdata[STAT_NEW])) new_q <= 1'b0;
      if (user_valid && new_q && !rd_clr) ovr_q <= 1'b1;
      else if (w1c && wdata[STAT_OVR]) ovr_q <= 1'b0;
    end
  end

  assign Sl_xferAck = ack;
  assign Sl_DBus    = ack ? reg_to_opb(rd_q) : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// tb/tb_opb_register_simulink2ppc.sv - directed self-checking bench for opb_register_simulink2ppc
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus_w;
  logic        rnw, sel, seq_addr;
  logic [0:31] dbus_r;
  logic        xfer_ack, err_ack, retry, tout_sup;
  logic [31:0] user_data;
  logic        user_valid;

  int          checks = 0;
  int          errors = 0;
  logic        cap_in_ack;
  logic [31:0] cap_val;
  logic [0:31] last_raw;
  logic [31:0] rd;

  always #5 clk = ~clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk     (clk),
    .OPB_Rst_n   (rst_n),
    .OPB_ABus    (abus),
    .OPB_BE      (be),
    .OPB_DBus    (dbus_w),
    .OPB_RNW     (rnw),
    .OPB_select  (sel),
    .OPB_seqAddr (seq_addr),
    .Sl_DBus     (dbus_r),
    .Sl_xferAck  (xfer_ack),
    .Sl_errAck   (err_ack),
    .Sl_retry    (retry),
    .Sl_toutSup  (tout_sup),
    .user_data_in(user_data),
    .user_valid  (user_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] v);
    @(posedge clk); #1;
    user_valid = 1'b1;
    user_data  = v;
    @(posedge clk); #1;
    user_valid = 1'b0;
  endtask

  // One OPB access; checks latency, single-cycle ack and zero data bus outside the ack.
  task automatic xfer(input string tag, input logic [31:0] offs, input logic r,
                      input logic [31:0] wd, input logic [3:0] b, output logic [31:0] rdata);
    int n;
    rdata = '0;
    @(posedge clk); #1;
    abus = BASE + offs; rnw = r; dbus_w = wd; be = b; sel = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (xfer_ack) break;
      if (dbus_r !== '0) check_eq({tag, " dbus_idle"}, dbus_r, 32'd0);
      if (n > 6) break;
    end
    check_eq({tag, " ack_latency"}, n, 2);
    rdata    = dbus_r;
    last_raw = dbus_r;
    if (cap_in_ack) begin
      user_valid = 1'b1;
      user_data  = cap_val;
    end
    @(posedge clk); #1;
    sel = 1'b0; user_valid = 1'b0; cap_in_ack = 1'b0;
    @(negedge clk);
    check_eq({tag, " gap_ack_dbus"}, {xfer_ack, dbus_r[1:31]}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; abus = '0; be = '0; dbus_w = '0; rnw = 1'b1; sel = 1'b0;
    seq_addr = 1'b0; user_data = '0; user_valid = 1'b0; cap_in_ack = 1'b0; cap_val = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    check_eq("reset ack", {31'd0, xfer_ack}, 32'd0);
    check_eq("const outs", {29'd0, err_ack, retry, tout_sup}, 32'd0);
    xfer("rst data",   32'h0, 1'b1, 32'd0, 4'hF, rd); check_eq("rst data",   rd, 32'h0);
    xfer("rst status", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("rst status", rd, 32'h0);
    xfer("rst count",  32'h8, 1'b1, 32'd0, 4'hF, rd); check_eq("rst count",  rd, 32'h0);

    strobe(32'hDEAD_BEEF);
    xfer("st1", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("status new", rd, 32'h1);
    xfer("d1",  32'h0, 1'b1, 32'd0, 4'hF, rd); check_eq("data deadbeef", rd, 32'hDEAD_BEEF);
    check_eq("dbus[0:7]", {24'd0, last_raw[0:7]}, 32'hDE);
    xfer("st2", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("status cleared", rd, 32'h0);
    xfer("c1",  32'h8, 1'b1, 32'd0, 4'hF, rd); check_eq("count 1", rd, 32'd1);

    strobe(32'h1);
    strobe(32'h2);
    xfer("st3", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("status ovr", rd, 32'h3);
    xfer("w1c ovr", 32'h4, 1'b0, 32'h2, 4'b0001, rd);
    xfer("st4", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("status after w1c", rd, 32'h1);
    xfer("w1c nobe", 32'h4, 1'b0, 32'h3, 4'b1110, rd);
    xfer("st5", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("status be masked", rd, 32'h1);
    xfer("d2",  32'h0, 1'b1, 32'd0, 4'hF, rd); check_eq("data 2", rd, 32'h2);
    xfer("st6", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("status after read", rd, 32'h0);

    strobe(32'h55);
    cap_in_ack = 1'b1; cap_val = 32'h66;
    xfer("d3",  32'h0, 1'b1, 32'd0, 4'hF, rd); check_eq("data old in ack", rd, 32'h55);
    xfer("st7", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("capture beats rdclr", rd, 32'h1);
    xfer("d4",  32'h0, 1'b1, 32'd0, 4'hF, rd); check_eq("data new", rd, 32'h66);

    strobe(32'h77);
    cap_in_ack = 1'b1; cap_val = 32'h88;
    xfer("w1c cap", 32'h4, 1'b0, 32'h3, 4'b0001, rd);
    xfer("st8", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("capture beats w1c", rd, 32'h3);
    xfer("w1c all", 32'h4, 1'b0, 32'h3, 4'b0001, rd);
    xfer("wr data", 32'h0, 1'b0, 32'hFFFF_FFFF, 4'hF, rd);
    xfer("st9", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("status w1c all", rd, 32'h0);
    xfer("d5",  32'h0, 1'b1, 32'd0, 4'hF, rd); check_eq("data ro", rd, 32'h88);
    xfer("c2",  32'h8, 1'b1, 32'd0, 4'hF, rd); check_eq("count 7", rd, 32'd7);

    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFE;
    #1 release dut.count_q;
    strobe(32'hA); strobe(32'hB); strobe(32'hC);
    xfer("c3",  32'h8, 1'b1, 32'd0, 4'hF, rd); check_eq("count wrap", rd, 32'd1);

    // Reset in the middle of an ACK cycle.
    @(posedge clk); #1;
    abus = BASE + 32'h8; rnw = 1'b1; sel = 1'b1;
    @(posedge clk); #2;
    check_eq("pre-reset ack", {31'd0, xfer_ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async ack drop", {31'd0, xfer_ack}, 32'd0);
    check_eq("async dbus drop", dbus_r, 32'd0);
    sel = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    xfer("r2 data",   32'h0, 1'b1, 32'd0, 4'hF, rd); check_eq("post-rst data",   rd, 32'h0);
    xfer("r2 status", 32'h4, 1'b1, 32'd0, 4'hF, rd); check_eq("post-rst status", rd, 32'h0);
    xfer("r2 count",  32'h8, 1'b1, 32'd0, 4'hF, rd); check_eq("post-rst count",  rd, 32'h0);
    xfer("hole",      32'h10, 1'b1, 32'd0, 4'hF, rd); check_eq("read 0x10", rd, 32'h0);
    xfer("top",       32'hFC, 1'b1, 32'd0, 4'hF, rd); check_eq("read 0xFC", rd, 32'h0);

    // Outside the window: never acked.
    @(posedge clk); #1;
    abus = BASE + 32'h100; rnw = 1'b1; sel = 1'b1;
    begin
      int acks = 0;
      repeat (5) begin
        @(negedge clk);
        if (xfer_ack) acks++;
      end
      check_eq("out of window no ack", acks, 0);
    end
    sel = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_register_simulink2ppc.md
# opb_register_simulink2ppc

OPB slave register that carries a 32-bit value from user fabric logic to the PowerPC, the read-direction counterpart of the CPU-to-fabric software register. User logic presents a word with a one-cycle valid strobe. The block captures it into a holding register, tracks new-data and overrun flags, counts captures, and answers OPB reads from a three-word window. It sits on the OPB alongside the other software registers, in the same clock domain as the user logic that feeds it.

## Interface
- C_BASEADDR, 32'h01000000, window base (word aligned)
- C_HIGHADDR, 32'h010000FF, window top; any address in [BASE,HIGH] is decoded
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex6", target family (informational)
- OPB_Clk  in  1  single clock: OPB bus and user logic
- OPB_Rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; BE[3] qualifies writes to bits 7:0
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck is 0
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  constant 0
- user_data_in  in  [31:0]  value to publish
- user_valid  in  1  capture strobe

## Operation
- Bit mapping: Sl_DBus[i] carries reg[31-i].
- Offset 0x0, DATA (RO): holding register, captured from user_data_in on every cycle with user_valid=1.
- Offset 0x4, STATUS:
  - bit0 = NEW: set on capture; cleared by an acked read of DATA.
  - bit1 = OVR: set on a capture while NEW=1 and no DATA read is acked that cycle.
  - Writing 1 (BE[3]=1) clears the bit. Bits 31:2 read 0.
- Offset 0x8, COUNT (RO): 32-bit capture counter; +1 per user_valid; wraps 0xFFFFFFFF to 0.
- Offsets 0xC to top: reads return 0; writes are acked and ignored. Writes to DATA and COUNT are ignored. Every decoded access is acked, and none raise errAck.
- FSM, with states IDLE, ACK and GAP:
  - IDLE to ACK when OPB_select=1 and the address is in the window; read data is registered on this edge.
  - ACK drives Sl_xferAck=1 for exactly one cycle, applies the read-clear or W1C, then goes to GAP.
  - GAP lasts one cycle and lets select drop, so there is no double ack. It then returns to IDLE.
- Precedence in one cycle:
  - A capture beats a W1C clear of NEW or OVR (the bit ends at 1).
  - A capture beats a DATA read-clear: NEW stays 1 and OVR is unchanged; the read returns the old DATA.
- Reset (asynchronous, any state): DATA, STATUS and COUNT go to 0, the FSM to IDLE, and Sl_xferAck and Sl_DBus to 0. An in-flight transfer is dropped without an ack.

## Timing
- Read or write latency is 2 cycles from the first select edge to Sl_xferAck high. The ack lasts one cycle, and Sl_DBus is valid in that same cycle.
- Minimum spacing between accesses is 3 cycles (IDLE, ACK, GAP).
- Capture: user_data_in is visible on DATA the cycle after the user_valid edge. COUNT and the flags update on the same edge.
- Read data is snapshotted on the IDLE-to-ACK edge. A capture during ACK does not alter the returned word.
- user_valid is accepted every cycle; there is no backpressure.
- The clear takes effect on the ACK-to-GAP edge.

## Structure
- A shared package holds:
  - the offset constants (DATA=0x0, STATUS=0x4, COUNT=0x8) and the STATUS bit indices;
  - the FSM state enum;
  - the bit-reverse function between [0:31] and [31:0].
- One sub-module: opb_slave_ack_fsm. It contains address decode, the IDLE/ACK/GAP FSM, and read/write qualifiers. The top holds the registers and the read mux.

## Test plan
- Reset then read 0x0, 0x4, 0x8: all return 0; ack arrives 2 cycles after select and lasts one cycle; Sl_DBus is 0 outside the ack.
- user_valid with 0xDEADBEEF, then read STATUS, then DATA, then STATUS:
  - STATUS returns 0x1; DATA returns 0xDEADBEEF with Sl_DBus[0:7]=0xDE; the final STATUS returns 0x0.
- Two captures (0x1 then 0x2) with no read: STATUS=0x3 and DATA=0x2. Write 0x2 with BE=0001: STATUS=0x1. Write with BE=1110: no change.
- Capture in the ACK cycle of a DATA read: the read returns the old value, and afterwards NEW=1 and OVR=0.
- Preload COUNT to 0xFFFFFFFE via 2³²-2 strobes (or force), then 3 strobes: COUNT=0x1.
- Assert OPB_Rst_n low during ACK: Sl_xferAck drops asynchronously and all registers read 0 after release. A read at 0x10 returns 0 with an ack.
